imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-serial program loader that writes the processor's instruction memory and holds the core in reset while loading.
- Accepts a framed byte stream on a valid/ready handshake: 16-bit word count, then little-endian instruction words, then an XOR checksum byte.
- Issues one-cycle word writes to the instruction-memory write port.
- Releases the core's reset only after a checksum-verified load.
- Sits between the external load interface and the top-level processor's instruction memory and reset input.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory; DEPTH = 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: begin a new load frame
in_data  input  8  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe (one cycle per word)
imem_addr  output  ADDR_WIDTH  word index; byte PC = imem_addr*4
imem_wdata  output  32  instruction word
cpu_reset  output  1  hold processor in reset (1 = held)
done  output  1  last load verified; core running
err  output  1  last load failed (length or checksum)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE; in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, err 0. Internal byte counter, word counter, length and checksum are cleared.
- All outputs are registered. A byte transfers only on a cycle where in_valid && in_ready.
- in_ready = 1 in LEN0, LEN1, DATA and CSUM; 0 in IDLE, RUN and ERR.
- States and transitions:
  - IDLE: start -> LEN0 (clears checksum and counters).
  - LEN0: accept byte -> length[7:0]; go to LEN1.
  - LEN1: accept byte -> length[15:8]; go to DATA.
    - If the new length > DEPTH, go to ERR instead.
    - If length == 0, go straight to CSUM.
  - DATA: bytes are assembled little-endian (1st byte = bits 7:0).
    - On acceptance of the 4th byte of a word: the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=word index. imem_we is high for exactly one cycle.
    - The word index then increments.
    - After word N-1 is accepted, go to CSUM.
  - CSUM: accept byte.
    - If it equals the running XOR of every prior frame byte (both length bytes and all data bytes), go to RUN.
    - Otherwise go to ERR.
  - RUN: done=1, cpu_reset=0.
  - ERR: err=1, cpu_reset=1.
  - From RUN or ERR, start -> LEN0: clears done/err and sets cpu_reset=1 in the next cycle.
- start is ignored in LEN0, LEN1, DATA and CSUM.
- cpu_reset is 1 in every state except RUN. It falls, and done rises, in the cycle after the checksum byte is accepted.
- The final data word's write may coincide with acceptance of the checksum byte. Both actions proceed.
- in_valid may drop at any point; the partial word and byte position are held.
- No address wrap: length > DEPTH is rejected before any write occurs.
- Reset mid-frame aborts immediately to IDLE:
  - no further writes;
  - the partially assembled word is discarded;
  - memory already written is not cleared.

Test Plan:
- Nominal load, N=2:
  - stimulus: start, then bytes 02 00 93 00 50 00 13 01 A0 00 73;
  - required: writes addr0=0x00500093 and addr1=0x00A00113, one cycle each; then done=1, err=0, cpu_reset=0.
- Bad checksum: same frame with final byte 74 -> both words written, err=1, done=0, cpu_reset stays 1.
- Empty program: start, bytes 00 00 00 -> no imem_we pulses; done=1, cpu_reset=0.
- Length overflow (ADDR_WIDTH=8): start, bytes 01 01 -> ERR right after the 2nd byte; in_ready=0, no writes, err=1.
- Stalls and ignored start:
  - stimulus: the nominal frame with in_valid low 3 cycles between each byte, and start pulsed during DATA;
  - required: identical writes and completion as the nominal load; start has no effect.
- Reset and reload:
  - stimulus: assert reset after the 5th byte of the nominal frame;
  - required: the next cycle shows state IDLE, imem_we=0, cpu_reset=1, done=0, err=0; a full nominal frame afterwards completes correctly.
  - Then, while in RUN, pulse start -> cpu_reset=1 and done=0 in the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-serial loader (start/in_* frame in) writing imem_* words, holding cpu_reset until checksum passes, reporting done/err
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
  state_t                r_state, w_next;
  logic [15:0]           r_len;
  logic [7:0]            r_csum;
  logic [1:0]            r_byte;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [23:0]           r_asm;
  logic                  w_fire, w_last;
  logic [15:0]           w_len;
  assign w_fire = in_valid && in_ready;
  assign w_len  = {in_data, r_len[7:0]};
  assign w_last = r_byte == 2'd3 && 16'(r_word) == r_len - 16'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RUN, ERR: w_next = start ? LEN0 : r_state;
      LEN0:    w_next = w_fire ? LEN1 : LEN0;
      LEN1:    w_next = !w_fire ? LEN1 : {1'b0, w_len} > DEPTH ? ERR : w_len == 16'd0 ? CSUM : DATA;
      DATA:    w_next = w_fire && w_last ? CSUM : DATA;
      CSUM:    w_next = !w_fire ? CSUM : in_data == r_csum ? RUN : ERR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_csum     <= '0;
      r_byte     <= '0;
      r_word     <= '0;
      r_asm      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state   <= w_next;
      in_ready  <= w_next inside {LEN0, LEN1, DATA, CSUM};
      cpu_reset <= w_next != RUN;
      done      <= w_next == RUN;
      err       <= w_next == ERR;
      imem_we   <= w_fire && r_state == DATA && r_byte == 2'd3;
      if (start && r_state inside {IDLE, RUN, ERR}) begin
        r_len  <= '0;
        r_csum <= '0;
        r_byte <= '0;
        r_word <= '0;
      end
      if (w_fire) begin
        if (r_state != CSUM) r_csum <= r_csum ^ in_data;
        if (r_state == LEN0) r_len[7:0] <= in_data;
        if (r_state == LEN1) r_len[15:8] <= in_data;
        if (r_state == DATA) begin
          r_byte <= r_byte + 2'd1;
          r_asm  <= {in_data, r_asm[23:8]};
          if (r_byte == 2'd3) begin
            imem_wdata <= {in_data, r_asm};
            imem_addr  <= r_word;
            r_word     <= r_word + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, imem_we, cpu_reset, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  int          n_chk = 0, n_fail = 0, nw = 0, b = 0;
  logic [7:0]  wa [0:1023];
  logic [31:0] wd [0:1023];
  localparam logic [7:0] NOM [0:9] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we && nw < 1024) begin
    wa[nw] = imem_addr;
    wd[nw] = imem_wdata;
    nw++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    int t = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = v;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic nominal(input logic [7:0] last, input int gap);
    b = nw;
    pulse_start();
    for (int i = 0; i < 10; i++) send(NOM[i], gap);
    send(last, gap);
  endtask

  task automatic chk_words;
    chk("nwrites", 32'(nw - b), 32'd2);
    chk("w0_addr", 32'(wa[b]), 32'd0);
    chk("w0_data", wd[b], 32'h00500093);
    chk("w1_addr", 32'(wa[b+1]), 32'd1);
    chk("w1_data", wd[b+1], 32'h00A00113);
  endtask

  task automatic chk_run;
    chk("done", 32'(done), 32'd1);
    chk("err", 32'(err), 32'd0);
    chk("cpu_reset", 32'(cpu_reset), 32'd0);
    chk("ready_run", 32'(in_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    nominal(8'h73, 0);
    chk_words();
    chk_run();

    b = nw;
    pulse_start();
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) send(NOM[i], 0);
    send(8'h74, 0);
    chk_words();
    chk("badcs_err", 32'(err), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("badcs_hold", 32'(cpu_reset), 32'd1);

    b = nw;
    pulse_start();
    chk("err_restart", 32'(err), 32'd0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("empty_csum_state", 32'(dut.r_state), 32'd4);
    send(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("empty_nwrites", 32'(nw - b), 32'd0);
    chk_run();

    b = nw;
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    chk("ovf_state", 32'(dut.r_state), 32'd6);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_nwrites", 32'(nw - b), 32'd0);

    b = nw;
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    chk("full_state", 32'(dut.r_state), 32'd3);
    for (int i = 0; i < 1024; i++) send(8'(i), 0);
    send(8'h01, 0);
    chk("full_nwrites", 32'(nw - b), 32'd256);
    chk("full_w0", wd[b], 32'h03020100);
    chk("full_a255", 32'(wa[b+255]), 32'd255);
    chk("full_w255", wd[b+255], 32'hFFFEFDFC);
    chk_run();

    b = nw;
    pulse_start();
    for (int i = 0; i < 4; i++) send(NOM[i], 3);
    pulse_start();
    chk("ign_start_state", 32'(dut.r_state), 32'd3);
    chk("ign_start_ready", 32'(in_ready), 32'd1);
    for (int i = 4; i < 10; i++) send(NOM[i], 3);
    send(8'h73, 3);
    chk_words();
    chk_run();

    b = nw;
    pulse_start();
    for (int i = 0; i < 5; i++) send(NOM[i], 0);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("mid_rst_state", 32'(dut.r_state), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nominal(8'h73, 0);
    chk_words();
    chk_run();

    pulse_start();
    chk("run_start_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("run_start_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
